rgb_pwm_sequencer: RTL and testbench

Parametrised successor to the single-button RGB LED controller. A debounced button steps through an 8-entry colour palette. Each colour channel is driven by a PWM generator whose resolution is set by a parameter. A long press toggles an auto-cycle mode that advances the colour on a timer. The block sits between the raw board button pin and the three LED pins at the top of the design.

---
 rtl/rgb_pwm_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_rgb_pwm_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_sequencer.sv
// Button-driven RGB LED sequencer: debounced short presses step an 8-colour palette,
// a long press toggles timed auto-cycling, and each channel is driven by a PWM comparator.
module rgb_pwm_sequencer #(
    parameter int PWM_BITS          = 8,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 1000000,
    parameter int STEP_CYCLES       = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic [2:0] color_idx,
    output logic       auto_mode
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int SW = $clog2(STEP_CYCLES);

    localparam logic [PWM_BITS-1:0] FULL     = '1;
    localparam logic [PWM_BITS-1:0] HALF     = {1'b1, {(PWM_BITS-1){1'b0}}};
    localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [DW-1:0]       DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]       HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0]       HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);

    logic                sync1;
    logic                sync2;
    logic                deb;
    logic                deb_prev;
    logic [DW-1:0]       deb_cnt;
    logic [HW-1:0]       hold_cnt;
    logic [SW-1:0]       step_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_r;
    logic [PWM_BITS-1:0] duty_g;
    logic [PWM_BITS-1:0] duty_b;
    logic                rise;
    logic                fall;
    logic                long_hit;
    logic                short_press;
    logic                step_tick;
    logic                advance;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // The level only flips once the synchronised input has disagreed for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else if (sync2 != deb) begin
            if (deb_cnt == DEB_LAST) begin
                deb     <= ~deb;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_prev <= 1'b0;
        end else begin
            deb_prev <= deb;
        end
    end

    always_comb begin
        rise        = deb & ~deb_prev;
        fall        = ~deb & deb_prev;
        long_hit    = deb && !rise && (hold_cnt == HOLD_LAST);
        short_press = fall && (hold_cnt != HOLD_MAX);
        step_tick   = auto_mode && (step_cnt == STEP_LAST);
        advance     = short_press || step_tick;
    end

    // Saturation at HOLD_MAX is what marks a press as long when it is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (rise) begin
            hold_cnt <= '0;
        end else if (deb && (hold_cnt != HOLD_MAX)) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            auto_mode <= 1'b0;
        end else if (long_hit) begin
            auto_mode <= ~auto_mode;
        end
    end

    // Any advance (manual or timed) restarts the step interval, so a coinciding pair counts once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt <= '0;
        end else if (!auto_mode || long_hit || advance) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            color_idx <= 3'd0;
        end else if (advance) begin
            color_idx <= color_idx + 3'd1;
        end
    end

    always_comb begin
        duty_r = '0;
        duty_g = '0;
        duty_b = '0;
        case (color_idx)
            3'd1: duty_r = FULL;
            3'd2: duty_g = FULL;
            3'd3: duty_b = FULL;
            3'd4: begin
                duty_r = FULL;
                duty_g = FULL;
            end
            3'd5: begin
                duty_g = FULL;
                duty_b = FULL;
            end
            3'd6: begin
                duty_r = FULL;
                duty_b = FULL;
            end
            3'd7: begin
                duty_r = HALF;
                duty_g = HALF;
                duty_b = HALF;
            end
            default: ;
        endcase
    end

    // Counter stops one short of FULL so a FULL duty stays high for the whole period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            red   <= 1'b0;
            green <= 1'b0;
            blue  <= 1'b0;
        end else begin
            red   <= duty_r > pwm_cnt;
            green <= duty_g > pwm_cnt;
            blue  <= duty_b > pwm_cnt;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer with small parameters so debounce, long press,
// auto stepping and PWM duty can all be observed within a few hundred clocks.
module tb_rgb_pwm_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       button;
    logic       red;
    logic       green;
    logic       blue;
    logic [2:0] color_idx;
    logic       auto_mode;

    int total = 0;
    int bad   = 0;

    // Expected lit clocks per 7-clock PWM period for each palette entry.
    int exp_r [8] = '{0, 7, 0, 0, 7, 0, 7, 4};
    int exp_g [8] = '{0, 0, 7, 0, 7, 7, 0, 4};
    int exp_b [8] = '{0, 0, 0, 7, 0, 7, 7, 4};

    rgb_pwm_sequencer #(
        .PWM_BITS(3),
        .DEBOUNCE_CYCLES(4),
        .LONG_PRESS_CYCLES(20),
        .STEP_CYCLES(50)
    ) dut (
        .clk(clk),
        .reset(reset),
        .button(button),
        .red(red),
        .green(green),
        .blue(blue),
        .color_idx(color_idx),
        .auto_mode(auto_mode)
    );

    always #5 clk = ~clk;

    task automatic wait_clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        button = 1'b0;
        wait_clocks(3);
        reset = 1'b1;
        wait_clocks(2);
    endtask

    task automatic short_press();
        button = 1'b1;
        wait_clocks(10);
        button = 1'b0;
        wait_clocks(20);
    endtask

    task automatic test_reset();
        int lit;
        reset  = 1'b0;
        button = 1'b0;
        wait_clocks(3);
        total++;
        if ({red, green, blue, color_idx, auto_mode} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: got %b expected 0000000", {red, green, blue, color_idx, auto_mode});
        end
        reset = 1'b1;
        lit = 0;
        for (int i = 0; i < 100; i++) begin
            wait_clocks(1);
            lit += int'(red) + int'(green) + int'(blue);
        end
        total++;
        if (lit != 0) begin
            bad++;
            $display("[TB] FAIL idle_leds: lit samples %0d expected 0", lit);
        end
        total++;
        if (color_idx !== 3'd0 || auto_mode !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_state: idx=%0d auto=%b expected idx=0 auto=0", color_idx, auto_mode);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        button = 1'b1;
        wait_clocks(3);
        button = 1'b0;
        wait_clocks(20);
        total++;
        if (color_idx !== 3'd0) begin
            bad++;
            $display("[TB] FAIL glitch_3clk: idx=%0d expected 0", color_idx);
        end
        button = 1'b1;
        wait_clocks(1);
        button = 1'b0;
        wait_clocks(20);
        total++;
        if (color_idx !== 3'd0) begin
            bad++;
            $display("[TB] FAIL glitch_1clk: idx=%0d expected 0", color_idx);
        end
        button = 1'b1;
        wait_clocks(4);
        button = 1'b0;
        wait_clocks(20);
        total++;
        if (color_idx !== 3'd1) begin
            bad++;
            $display("[TB] FAIL pulse_4clk: idx=%0d expected 1", color_idx);
        end
    endtask

    task automatic test_single_press();
        int rc;
        int gc;
        int bc;
        do_reset();
        button = 1'b1;
        wait_clocks(10);
        button = 1'b0;
        wait_clocks(6);
        total++;
        if (color_idx !== 3'd0) begin
            bad++;
            $display("[TB] FAIL press_early: idx=%0d expected 0", color_idx);
        end
        wait_clocks(1);
        total++;
        if (color_idx !== 3'd1) begin
            bad++;
            $display("[TB] FAIL press_latency: idx=%0d expected 1", color_idx);
        end
        wait_clocks(2);
        rc = 0;
        gc = 0;
        bc = 0;
        for (int i = 0; i < 14; i++) begin
            wait_clocks(1);
            rc += int'(red);
            gc += int'(green);
            bc += int'(blue);
        end
        total++;
        if (rc != 14 || gc != 0 || bc != 0) begin
            bad++;
            $display("[TB] FAIL red_full: r=%0d g=%0d b=%0d expected r=14 g=0 b=0", rc, gc, bc);
        end
    endtask

    task automatic test_wrap();
        int rc;
        int gc;
        int bc;
        int want;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            short_press();
            want = i % 8;
            total++;
            if (color_idx !== 3'(want)) begin
                bad++;
                $display("[TB] FAIL wrap_idx: step %0d idx=%0d expected %0d", i, color_idx, want);
            end
            wait_clocks(2);
            rc = 0;
            gc = 0;
            bc = 0;
            for (int k = 0; k < 7; k++) begin
                wait_clocks(1);
                rc += int'(red);
                gc += int'(green);
                bc += int'(blue);
            end
            total++;
            if (rc != exp_r[want] || gc != exp_g[want] || bc != exp_b[want]) begin
                bad++;
                $display("[TB] FAIL palette_duty: idx %0d got r=%0d g=%0d b=%0d expected r=%0d g=%0d b=%0d",
                         want, rc, gc, bc, exp_r[want], exp_g[want], exp_b[want]);
            end
        end
    endtask

    task automatic test_long_press();
        do_reset();
        button = 1'b1;
        wait_clocks(26);
        total++;
        if (auto_mode !== 1'b0) begin
            bad++;
            $display("[TB] FAIL long_early: auto=%b expected 0", auto_mode);
        end
        wait_clocks(1);
        total++;
        if (auto_mode !== 1'b1) begin
            bad++;
            $display("[TB] FAIL long_toggle_on: auto=%b expected 1", auto_mode);
        end
        wait_clocks(3);
        button = 1'b0;
        wait_clocks(46);
        total++;
        if (color_idx !== 3'd0) begin
            bad++;
            $display("[TB] FAIL long_release: idx=%0d expected 0", color_idx);
        end
        wait_clocks(1);
        total++;
        if (color_idx !== 3'd1) begin
            bad++;
            $display("[TB] FAIL auto_step1: idx=%0d expected 1", color_idx);
        end
        wait_clocks(50);
        total++;
        if (color_idx !== 3'd2) begin
            bad++;
            $display("[TB] FAIL auto_step2: idx=%0d expected 2", color_idx);
        end
        button = 1'b1;
        wait_clocks(26);
        total++;
        if (auto_mode !== 1'b1) begin
            bad++;
            $display("[TB] FAIL long2_early: auto=%b expected 1", auto_mode);
        end
        wait_clocks(1);
        total++;
        if (auto_mode !== 1'b0) begin
            bad++;
            $display("[TB] FAIL long_toggle_off: auto=%b expected 0", auto_mode);
        end
        wait_clocks(3);
        button = 1'b0;
        wait_clocks(120);
        total++;
        if (color_idx !== 3'd2 || auto_mode !== 1'b0) begin
            bad++;
            $display("[TB] FAIL auto_frozen: idx=%0d auto=%b expected idx=2 auto=0", color_idx, auto_mode);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        button = 1'b1;
        wait_clocks(30);
        button = 1'b0;
        wait_clocks(30);
        button = 1'b1;
        wait_clocks(10);
        button = 1'b0;
        wait_clocks(6);
        total++;
        if (color_idx !== 3'd0) begin
            bad++;
            $display("[TB] FAIL coincide_before: idx=%0d expected 0", color_idx);
        end
        wait_clocks(1);
        total++;
        if (color_idx !== 3'd1) begin
            bad++;
            $display("[TB] FAIL coincide_once: idx=%0d expected 1", color_idx);
        end
        wait_clocks(49);
        total++;
        if (color_idx !== 3'd1) begin
            bad++;
            $display("[TB] FAIL coincide_hold: idx=%0d expected 1", color_idx);
        end
        wait_clocks(1);
        total++;
        if (color_idx !== 3'd2) begin
            bad++;
            $display("[TB] FAIL coincide_next: idx=%0d expected 2", color_idx);
        end
        wait_clocks(6);
        button = 1'b1;
        wait_clocks(10);
        button = 1'b0;
        wait_clocks(6);
        total++;
        if (color_idx !== 3'd2) begin
            bad++;
            $display("[TB] FAIL auto_press_before: idx=%0d expected 2", color_idx);
        end
        wait_clocks(1);
        total++;
        if (color_idx !== 3'd3) begin
            bad++;
            $display("[TB] FAIL auto_press: idx=%0d expected 3", color_idx);
        end
        wait_clocks(49);
        total++;
        if (color_idx !== 3'd3) begin
            bad++;
            $display("[TB] FAIL timer_restart: idx=%0d expected 3", color_idx);
        end
        wait_clocks(1);
        total++;
        if (color_idx !== 3'd4) begin
            bad++;
            $display("[TB] FAIL timer_next: idx=%0d expected 4", color_idx);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        short_press();
        wait_clocks(2);
        button = 1'b1;
        wait_clocks(10);
        reset = 1'b0;
        #1;
        total++;
        if ({red, green, blue, color_idx, auto_mode} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL async_reset: got %b expected 0000000", {red, green, blue, color_idx, auto_mode});
        end
        wait_clocks(2);
        button = 1'b0;
        reset  = 1'b1;
        wait_clocks(100);
        total++;
        if (color_idx !== 3'd0 || auto_mode !== 1'b0) begin
            bad++;
            $display("[TB] FAIL press_discarded: idx=%0d auto=%b expected idx=0 auto=0", color_idx, auto_mode);
        end
        reset  = 1'b0;
        button = 1'b1;
        wait_clocks(2);
        reset = 1'b1;
        wait_clocks(10);
        button = 1'b0;
        wait_clocks(6);
        total++;
        if (color_idx !== 3'd0) begin
            bad++;
            $display("[TB] FAIL redebounce_early: idx=%0d expected 0", color_idx);
        end
        wait_clocks(1);
        total++;
        if (color_idx !== 3'd1) begin
            bad++;
            $display("[TB] FAIL redebounce_press: idx=%0d expected 1", color_idx);
        end
    endtask

    initial begin
        reset  = 1'b0;
        button = 1'b0;
        test_reset();
        test_glitch();
        test_single_press();
        test_wrap();
        test_long_press();
        test_back_to_back();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
